entropy_sampler: RTL and testbench

//  Consumes the free-running raw entropy bit from the ring-oscillator XOR tree. Synchronises it into
//  es_clk, decimates it, optionally debiases it, and packs the bits into WORD_W-bit words.

---
 rtl/entropy_sampler.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_entropy_sampler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_sampler.sv
// ============================================================================
// entropy_sampler
// ----------------------------------------------------------------------------
// Purpose
//   Turns the free-running raw bit of a ring-oscillator XOR tree into packed
//   entropy words for a TRNG consumer.
//     1. A two-flop synchroniser brings es_raw_in into the es_clk domain.
//     2. A divider picks one synchronised bit every SAMPLE_DIV clocks.
//     3. An optional von Neumann pair stage removes bias.
//     4. Emitted bits are packed MSB-first into WORD_W-bit words.
//     5. Words leave through a single-entry valid/ready output register.
//     6. A repetition-count health test flags a stuck source.
//
// Parameters
//   WORD_W      output word width in bits (>= 2)
//   SAMPLE_DIV  one synchronised bit is sampled every SAMPLE_DIV clocks (>= 1)
//   RCT_LIMIT   run of identical emitted bits that trips es_fail (>= 2)
//
// Optional feature (compile-time macro)
//   ES_VON_NEUMANN_EN  defined  : pair FSM (IDLE / HAVE_FIRST) debiases the
//                                 sampled stream. Pair 10 emits 1, pair 01
//                                 emits 0, pairs 00 and 11 are discarded.
//                      undefined: every divider strobe emits the
//                                 synchronised bit directly.
//
// Ports
//   es_clk      in   1       single clock, rising edge
//   es_rst      in   1       synchronous, active-high reset
//   es_raw_in   in   1       asynchronous raw entropy bit
//   es_enable   in   1       1 = sample; 0 = hold the divider at 0, return the
//                            pair FSM to IDLE and drop the partial word
//   es_data     out  WORD_W  packed entropy word
//   es_valid    out  1       es_data holds an unconsumed word
//   es_ready    in   1       consumer takes es_data when es_valid && es_ready
//   es_overrun  out  1       sticky: a completed word was dropped (output full)
//   es_fail     out  1       sticky: repetition-count test tripped
// ============================================================================
module entropy_sampler #(
    parameter int WORD_W     = 32,
    parameter int SAMPLE_DIV = 4,
    parameter int RCT_LIMIT  = 32
) (
    input  logic              es_clk,
    input  logic              es_rst,
    input  logic              es_raw_in,
    input  logic              es_enable,
    output logic [WORD_W-1:0] es_data,
    output logic              es_valid,
    input  logic              es_ready,
    output logic              es_overrun,
    output logic              es_fail
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    // SAMPLE_DIV = 1 still gets a one-bit counter. That counter simply stays
    // at 0, so the strobe fires on every enabled clock.
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    // WORD_W >= 2, so the counter is at least one bit wide. It only ever
    // holds 0..WORD_W-1.
    localparam int CNT_W = $clog2(WORD_W);
    // The run counter must be able to hold RCT_LIMIT itself.
    localparam int RUN_W = $clog2(RCT_LIMIT + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_LIMIT);

    // ------------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------------
    // es_raw_in has no relationship to es_clk. The chain is a plain flop-to-
    // flop path, and it must stay that way: no logic between the stages, and
    // no retiming or merging by synthesis. The attributes mark both stages as
    // preserved asynchronous-capture flops.
    (* keep = "true", async_reg = "true", dont_retime = "true" *) logic sync1_q;
    (* keep = "true", async_reg = "true", dont_retime = "true" *) logic sync2_q;

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments. Every flop then samples the values from before the edge,
    // so sync2_q really does receive the old sync1_q.
    always_ff @(posedge es_clk) begin
        if (es_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= es_raw_in;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------------
    // Sample divider
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             strobe;

    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block. A path that leaves an output unassigned would otherwise
    // infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q;
        strobe    = 1'b0;
        if (!es_enable) begin
            div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            strobe    = 1'b1;
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Emit path
    // ------------------------------------------------------------------------
    // emit     : one entropy bit leaves the front end this cycle
    // emit_bit : the value of that bit
    logic emit;
    logic emit_bit;

`ifdef ES_VON_NEUMANN_EN
    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_HAVE_FIRST = 1'b1;

    logic [0:0] vn_state_q, vn_state_d;
    logic       first_q, first_d;      // first sample of the current pair

    always_comb begin
        vn_state_d = vn_state_q;
        first_d    = first_q;
        emit       = 1'b0;
        // A mismatched pair always emits its first sample: 10 -> 1, 01 -> 0.
        emit_bit   = first_q;
        if (!es_enable) begin
            vn_state_d = ST_IDLE;
        end else if (strobe) begin
            case (vn_state_q)
                ST_IDLE: begin
                    first_d    = sync2_q;
                    vn_state_d = ST_HAVE_FIRST;
                end
                default: begin
                    // Equal pairs (00/11) carry no unbiased information.
                    emit       = (sync2_q != first_q);
                    vn_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge es_clk) begin
        if (es_rst) begin
            vn_state_q <= ST_IDLE;
            first_q    <= 1'b0;
        end else begin
            vn_state_q <= vn_state_d;
            first_q    <= first_d;
        end
    end
`else
    assign emit     = strobe;
    assign emit_bit = sync2_q;
`endif

    // ------------------------------------------------------------------------
    // Packing
    // ------------------------------------------------------------------------
    // Only WORD_W-1 bits are stored. The final bit of a word goes straight
    // from emit_bit into the output register, with no extra cycle of latency.
    logic [WORD_W-2:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0] word_full;
    logic              word_done;

    assign word_full = {sreg_q, emit_bit};

    always_comb begin
        sreg_d    = sreg_q;
        bitcnt_d  = bitcnt_q;
        word_done = 1'b0;
        if (!es_enable) begin
            // Disabling abandons the partial word. The next word starts clean.
            bitcnt_d = '0;
        end else if (emit) begin
            sreg_d = word_full[WORD_W-2:0];
            if (bitcnt_q == CNT_LAST) begin
                bitcnt_d  = '0;
                word_done = 1'b1;
            end else begin
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              out_free;
    logic              load_word;

    // The single output slot can accept a word when it is empty, or when its
    // current word is being taken on this same edge (back-to-back transfer).
    assign out_free  = !valid_q || es_ready;
    assign load_word = word_done && out_free;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load_word) begin
            data_d  = word_full;
            valid_d = 1'b1;
        end else if (valid_q && es_ready) begin
            valid_d = 1'b0;
        end
        if (word_done && !out_free) begin
            overrun_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Repetition-count health test
    // ------------------------------------------------------------------------
    // run_q == 0 only between reset and the first emitted bit. That lets the
    // counter double as the "no previous bit yet" flag.
    logic [RUN_W-1:0] run_q, run_d;
    logic             last_bit_q, last_bit_d;
    logic             fail_q, fail_d;

    always_comb begin
        run_d      = run_q;
        last_bit_d = last_bit_q;
        fail_d     = fail_q;
        if (emit) begin
            last_bit_d = emit_bit;
            if ((run_q != '0) && (emit_bit == last_bit_q)) begin
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                end
            end else begin
                run_d = RUN_W'(1);
            end
            if (run_d == RUN_MAX) begin
                fail_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // The shift register and bit counter are cleared along with the control
    // state. A reset therefore never lets stale bits from a partial word leak
    // into the first word after reset.
    always_ff @(posedge es_clk) begin
        if (es_rst) begin
            div_cnt_q  <= '0;
            sreg_q     <= '0;
            bitcnt_q   <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            run_q      <= '0;
            last_bit_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            sreg_q     <= sreg_d;
            bitcnt_q   <= bitcnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            run_q      <= run_d;
            last_bit_q <= last_bit_d;
            fail_q     <= fail_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign es_data    = data_q;
    assign es_valid   = valid_q;
    assign es_overrun = overrun_q;
    assign es_fail    = fail_q;

endmodule

// File: tb/tb_entropy_sampler.sv
// ============================================================================
// tb_entropy_sampler
// ----------------------------------------------------------------------------
// Bench for entropy_sampler.
//   dut_a : WORD_W=8, SAMPLE_DIV=1, RCT_LIMIT=4
//   dut_b : WORD_W=8, SAMPLE_DIV=1, RCT_LIMIT=5
//   dut_c : WORD_W=8, SAMPLE_DIV=4, RCT_LIMIT=4
// The stimulus processes push expected words into a per-instance queue.
// Independent monitors pop from the queue and compare on every accepted
// transfer.
// ============================================================================
module tb_entropy_sampler;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic         a_rst, a_en, a_raw, a_ready, a_valid, a_overrun, a_fail;
    logic [W-1:0] a_data;
    logic         b_rst, b_en, b_raw, b_ready, b_valid, b_overrun, b_fail;
    logic [W-1:0] b_data;
    logic         c_rst, c_en, c_raw, c_ready, c_valid, c_overrun, c_fail;
    logic [W-1:0] c_data;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [W-1:0] exp_c[$];

    entropy_sampler #(.WORD_W(W), .SAMPLE_DIV(1), .RCT_LIMIT(4)) dut_a (
        .es_clk(clk), .es_rst(a_rst), .es_raw_in(a_raw), .es_enable(a_en),
        .es_data(a_data), .es_valid(a_valid), .es_ready(a_ready),
        .es_overrun(a_overrun), .es_fail(a_fail)
    );

    entropy_sampler #(.WORD_W(W), .SAMPLE_DIV(1), .RCT_LIMIT(5)) dut_b (
        .es_clk(clk), .es_rst(b_rst), .es_raw_in(b_raw), .es_enable(b_en),
        .es_data(b_data), .es_valid(b_valid), .es_ready(b_ready),
        .es_overrun(b_overrun), .es_fail(b_fail)
    );

    entropy_sampler #(.WORD_W(W), .SAMPLE_DIV(4), .RCT_LIMIT(4)) dut_c (
        .es_clk(clk), .es_rst(c_rst), .es_raw_in(c_raw), .es_enable(c_en),
        .es_data(c_data), .es_valid(c_valid), .es_ready(c_ready),
        .es_overrun(c_overrun), .es_fail(c_fail)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_valid === 1'b1 && a_ready === 1'b1) begin
            if (exp_a.size() == 0) begin
                total++; bad++;
                $display("FAIL word_a: got=%0h expected=none", a_data);
            end else begin
                check("word_a", a_data, exp_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_valid === 1'b1 && b_ready === 1'b1) begin
            if (exp_b.size() == 0) begin
                total++; bad++;
                $display("FAIL word_b: got=%0h expected=none", b_data);
            end else begin
                check("word_b", b_data, exp_b.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (c_valid === 1'b1 && c_ready === 1'b1) begin
            if (exp_c.size() == 0) begin
                total++; bad++;
                $display("FAIL word_c: got=%0h expected=none", c_data);
            end else begin
                check("word_c", c_data, exp_c.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int sel, input logic raw, input logic en);
        case (sel)
            0:       begin a_raw = raw; a_en = en; end
            1:       begin b_raw = raw; b_en = en; end
            default: begin c_raw = raw; c_en = en; end
        endcase
    endtask

    // Drives n raw bits (MSB first), one per clock, on a SAMPLE_DIV=1 instance.
    // Enable rises two cycles after the first raw bit, so the first strobe sees
    // bits[n-1] out of the synchroniser. Unless keep_en is set, enable drops
    // right after the edge that captures the last bit.
    task automatic send_bits(input int sel, input logic [31:0] bits, input int n,
                             input bit keep_en);
        logic r;
        r = 1'b0;
        for (int c = 0; c < n + 2; c++) begin
            @(posedge clk); #1;
            if (c < n) r = bits[n-1-c];
            set_in(sel, r, c >= 2);
        end
        if (!keep_en) begin
            @(posedge clk); #1;
            set_in(sel, r, 1'b0);
        end
    endtask

    // SAMPLE_DIV=4 instance: each bit is held for 4 clocks, starting in the
    // cycle where enable rises. The strobe lands on the 4th clock and sees the
    // raw value from 2 clocks earlier.
    task automatic send_div4(input logic [31:0] bits, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(posedge clk); #1;
                c_raw = bits[n-1-k];
                c_en  = 1'b1;
            end
        end
        @(posedge clk); #1;
        c_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_raw = 1'b0; a_ready = 1'b1;
        b_rst = 1'b1; b_en = 1'b0; b_raw = 1'b0; b_ready = 1'b1;
        c_rst = 1'b1; c_en = 1'b0; c_raw = 1'b0; c_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_valid",   a_valid,   0);
        check("reset_data",    a_data,    0);
        check("reset_overrun", a_overrun, 0);
        check("reset_fail",    a_fail,    0);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

`ifdef ES_VON_NEUMANN_EN
        // Pairs 10,01,11,00 x4 -> emitted 1,0 per repeat -> 8'hAA.
        exp_a.push_back(8'hAA);
        send_bits(0, 32'h9C9C_9C9C, 32, 1'b0);
        @(negedge clk);
        check("vn_fail_after_aa", a_fail, 0);
        // Only equal pairs: nothing is emitted, and the held data is unchanged.
        send_bits(0, 32'h0000_CC3C, 16, 1'b0);
        @(negedge clk);
        check("vn_discard_valid", a_valid, 0);
        check("vn_discard_data",  a_data,  8'hAA);
        // 0,1,0,1,1,0,1,0 encoded as 01/10 pairs -> 8'h5A.
        exp_a.push_back(8'h5A);
        send_bits(0, 32'h0000_6699, 16, 1'b0);
        @(negedge clk);
        // Three 10 pairs emit 1,1,1: the run is 3, below the limit of 4.
        send_bits(0, 32'h0000_002A, 6, 1'b0);
        @(negedge clk);
        check("vn_rct_run3", a_fail, 0);
        send_bits(0, 32'h0000_0002, 2, 1'b0);
        @(negedge clk);
        check("vn_rct_run4", a_fail, 1);
        @(posedge clk); #1; a_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("vn_rst_fail",    a_fail,    0);
        check("vn_rst_overrun", a_overrun, 0);
        @(posedge clk); #1; a_rst = 1'b0;
`else
        // Direct path, ready=1: a single word 8'hB2.
        exp_a.push_back(8'hB2);
        send_bits(0, 32'h0000_00B2, 8, 1'b0);
        @(negedge clk);
        check("b2_fail", a_fail, 0);
        @(posedge clk); @(negedge clk);
        check("b2_valid_pulse", a_valid, 0);

        // 5 bits into a word, then a 1-cycle reset. Only the next 8 bits count.
        send_bits(0, 32'h0000_001B, 5, 1'b1);
        @(posedge clk); #1;
        a_rst = 1'b1; a_en = 1'b0;
        @(posedge clk); @(negedge clk);
        check("midrst_valid",   a_valid,   0);
        check("midrst_data",    a_data,    0);
        check("midrst_overrun", a_overrun, 0);
        check("midrst_fail",    a_fail,    0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        exp_a.push_back(8'hAA);
        send_bits(0, 32'h0000_00AA, 8, 1'b0);
        @(posedge clk); @(negedge clk);
        check("aa_valid_drop", a_valid, 0);

        // Backpressure: three words with ready low. Word 1 is held; words 2
        // and 3 are dropped and set overrun.
        @(posedge clk); #1;
        a_ready = 1'b0;
        send_bits(0, 32'h0000_005A, 8, 1'b0);
        @(negedge clk);
        check("bp_w1_valid",   a_valid,   1);
        check("bp_w1_data",    a_data,    8'h5A);
        check("bp_w1_overrun", a_overrun, 0);
        send_bits(0, 32'h0000_0069, 8, 1'b0);
        @(negedge clk);
        check("bp_w2_overrun", a_overrun, 1);
        check("bp_w2_data",    a_data,    8'h5A);
        send_bits(0, 32'h0000_0096, 8, 1'b0);
        @(negedge clk);
        check("bp_w3_data",  a_data,  8'h5A);
        check("bp_w3_valid", a_valid, 1);
        exp_a.push_back(8'h5A);
        @(posedge clk); #1;
        a_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("bp_drained_valid", a_valid, 0);

        // RCT_LIMIT=4: three 1s do not trip, the fourth does. Toggling does not
        // clear the flag.
        send_bits(0, 32'h0000_0007, 3, 1'b0);
        @(negedge clk);
        check("rct_run3", a_fail, 0);
        send_bits(0, 32'h0000_0001, 1, 1'b0);
        @(negedge clk);
        check("rct_run4", a_fail, 1);
        send_bits(0, 32'h0000_000A, 4, 1'b0);
        @(negedge clk);
        check("rct_sticky",     a_fail,    1);
        check("overrun_sticky", a_overrun, 1);
        @(posedge clk); #1; a_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_clears_fail",    a_fail,    0);
        check("rst_clears_overrun", a_overrun, 0);
        @(posedge clk); #1; a_rst = 1'b0;

        // RCT_LIMIT=5: run 1,1,1,1,0 is fine. A run of five 1s trips.
        send_bits(1, 32'h0000_001E, 5, 1'b0);
        @(negedge clk);
        check("rct5_run4", b_fail, 0);
        send_bits(1, 32'h0000_001F, 5, 1'b0);
        @(negedge clk);
        check("rct5_run5", b_fail, 1);

        // SAMPLE_DIV=4: 3 bits, then enable drops for 10 clocks while raw
        // toggles. The next word holds only post-enable samples: 8'hC5.
        exp_c.push_back(8'hC5);
        send_div4(32'h0000_0006, 3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            c_raw = ~c_raw;
        end
        send_div4(32'h0000_00C5, 8);
        @(negedge clk);
        check("div4_overrun", c_overrun, 0);
`endif

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_a_drained", exp_a.size(), 0);
        check("queue_b_drained", exp_b.size(), 0);
        check("queue_c_drained", exp_c.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
